// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter datapath.
package pc_pkg;

  // Byte width shared with the other datapath registers.
  localparam int unsigned DEFAULT_BYTE_W = 8;

  typedef enum logic {
    IDLE,
    FIXUP
  } pc_state_t;

  // Direction of the pending upper-lane adjust after a page-crossing branch.
  typedef enum logic {
    FIX_INC,
    FIX_DEC
  } fix_dir_t;

endpackage

// File: rtl/pc_unit_if.sv
// Command/data bus between decoder, data bus, address driver and pc_unit.
// Optional macro PC_WRAP_FLAG_EN adds the pc_wrap pulse output.
interface pc_unit_if import pc_pkg::*; #(
  parameter int unsigned BYTE_W    = DEFAULT_BYTE_W,
  parameter int unsigned NUM_BYTES = 2
);

  localparam int unsigned PC_W = BYTE_W * NUM_BYTES;

  logic              inc_pc;
  logic              branch_en;
  logic [BYTE_W-1:0] branch_off;
  logic              load_low_en;
  logic              load_high_en;
  logic [BYTE_W-1:0] db_in;
  logic              load_addr_en;
  logic [PC_W-1:0]   addr_in;
  logic [PC_W-1:0]   pc_out;
  logic [BYTE_W-1:0] db_low_out;
  logic [BYTE_W-1:0] db_high_out;
  logic              page_cross;
  logic              busy;
`ifdef PC_WRAP_FLAG_EN
  logic              pc_wrap;
`endif

  modport master (
    output inc_pc, branch_en, branch_off, load_low_en, load_high_en, db_in,
           load_addr_en, addr_in,
`ifdef PC_WRAP_FLAG_EN
    input  pc_wrap,
`endif
    input  pc_out, db_low_out, db_high_out, page_cross, busy
  );

  modport slave (
    input  inc_pc, branch_en, branch_off, load_low_en, load_high_en, db_in,
           load_addr_en, addr_in,
`ifdef PC_WRAP_FLAG_EN
    output pc_wrap,
`endif
    output pc_out, db_low_out, db_high_out, page_cross, busy
  );

endinterface

// File: rtl/pc_lane.sv
// One byte lane of the PC: load, or step by +/-1 when carry_in is set.
module pc_lane import pc_pkg::*; #(
  parameter int unsigned BYTE_W = DEFAULT_BYTE_W
) (
  input  logic              fclk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rst_val,
  input  logic              load_en,
  input  logic [BYTE_W-1:0] load_val,
  input  logic              carry_in,
  input  fix_dir_t          adj_dir,
  output logic [BYTE_W-1:0] lane_q,
  output logic              carry_out
);

  localparam logic [BYTE_W-1:0] One = {{(BYTE_W-1){1'b0}}, 1'b1};

  // Carry (or borrow when decrementing) ripples out when the lane wraps.
  assign carry_out = carry_in & ((adj_dir == FIX_DEC) ? (lane_q == '0) : (lane_q == '1));

  // Lane register: reset, then load, then +/-1 step.
  always_ff @(posedge fclk) begin
    if (reset) begin
      lane_q <= rst_val;
    end else if (load_en) begin
      lane_q <= load_val;
    end else if (carry_in) begin
      lane_q <= (adj_dir == FIX_DEC) ? (lane_q - One) : (lane_q + One);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Multi-byte program counter with byte/full loads, increment and relative
// branches; a branch crossing a lane-0 boundary fixes the upper lanes one
// cycle later. Optional macro PC_WRAP_FLAG_EN adds the pc_wrap pulse.
module pc_unit import pc_pkg::*; #(
  parameter int unsigned                   BYTE_W    = DEFAULT_BYTE_W,
  parameter int unsigned                   NUM_BYTES = 2,
  parameter logic [BYTE_W*NUM_BYTES-1:0]   RESET_PC  = 16'hFFFC
) (
  input logic       fclk,
  input logic       reset,
  pc_unit_if.slave  bus
);

  localparam int unsigned PC_W = BYTE_W * NUM_BYTES;
  localparam int unsigned TOP  = NUM_BYTES - 1;

  pc_state_t state_q, state_d;
  fix_dir_t  dir_q, dir_d, lane_dir;
  logic      page_cross_q, page_cross_d;
  logic      inc_cmd, fix_cmd;
  logic      br_cross;
  logic [BYTE_W:0] br_sum;

  logic [NUM_BYTES-1:0][BYTE_W-1:0] lane_q, load_val, addr_lanes, rst_lanes;
  logic [NUM_BYTES-1:0]             load_en;

  assign addr_lanes = bus.addr_in;
  assign rst_lanes  = RESET_PC;

  // Crossing: carry out for a positive offset, missing carry (borrow) for a negative one.
  assign br_sum   = {1'b0, lane_q[0]} + {1'b0, bus.branch_off};
  assign br_cross = (NUM_BYTES > 1) &&
                    (bus.branch_off[BYTE_W-1] ? ~br_sum[BYTE_W] : br_sum[BYTE_W]);
  assign lane_dir = fix_cmd ? dir_q : FIX_INC;

  // Command decode and next state.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    page_cross_d = 1'b0;
    load_en      = '0;
    load_val     = addr_lanes;
    inc_cmd      = 1'b0;
    fix_cmd      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.load_addr_en) begin
          load_en = '1;
        end else if (bus.load_low_en || bus.load_high_en) begin
          if (bus.load_high_en) begin
            load_en[TOP]  = 1'b1;
            load_val[TOP] = bus.db_in;
          end
          if (bus.load_low_en) begin
            load_en[0]  = 1'b1;
            load_val[0] = bus.db_in;
          end
        end else if (bus.branch_en) begin
          load_en[0]  = 1'b1;
          load_val[0] = br_sum[BYTE_W-1:0];
          if (br_cross) begin
            state_d      = FIXUP;
            dir_d        = bus.branch_off[BYTE_W-1] ? FIX_DEC : FIX_INC;
            page_cross_d = 1'b1;
          end
        end else if (bus.inc_pc) begin
          inc_cmd = 1'b1;
        end
      end
      FIXUP: begin
        state_d = IDLE;
        if (bus.load_addr_en) begin
          load_en = '1;
        end else begin
          fix_cmd = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge fclk) begin
    if (reset) begin
      state_q      <= IDLE;
      dir_q        <= FIX_INC;
      page_cross_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      page_cross_q <= page_cross_d;
    end
  end

  // Lane 0 is the increment entry point; lane 1 is the fix-up entry point.
  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
    logic cin;
    logic cout;
    if (i == 0) begin : g_c0
      assign cin = inc_cmd;
    end else if (i == 1) begin : g_c1
      assign cin = fix_cmd | g_lane[0].cout;
    end else begin : g_cn
      assign cin = g_lane[i-1].cout;
    end
    pc_lane #(.BYTE_W(BYTE_W)) u_lane (
      .fclk      (fclk),
      .reset     (reset),
      .rst_val   (rst_lanes[i]),
      .load_en   (load_en[i]),
      .load_val  (load_val[i]),
      .carry_in  (cin),
      .adj_dir   (lane_dir),
      .lane_q    (lane_q[i]),
      .carry_out (cout)
    );
  end

`ifdef PC_WRAP_FLAG_EN
  logic pc_wrap_q;

  // Wrap pulse: carry out of the top lane during an increment or fix-up.
  always_ff @(posedge fclk) begin
    if (reset) begin
      pc_wrap_q <= 1'b0;
    end else begin
      pc_wrap_q <= (inc_cmd | fix_cmd) & g_lane[TOP].cout;
    end
  end

  assign bus.pc_wrap = pc_wrap_q;
`else
  logic unused_top_carry;
  assign unused_top_carry = g_lane[TOP].cout;
`endif

  assign bus.pc_out      = PC_W'(lane_q);
  assign bus.db_low_out  = lane_q[0];
  assign bus.db_high_out = lane_q[TOP];
  assign bus.page_cross  = page_cross_q;
  assign bus.busy        = (state_q == FIXUP);

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit (16-bit PC, two byte lanes).
module tb_pc_unit;

  logic fclk = 1'b0;
  logic reset;

  always #5 fclk = ~fclk;

  pc_unit_if #(.BYTE_W(8), .NUM_BYTES(2)) bus ();

  pc_unit #(.BYTE_W(8), .NUM_BYTES(2), .RESET_PC(16'hFFFC)) dut (
    .fclk  (fclk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic        pcross;
    logic        busy;
    logic        wrap;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [15:0] m_pc, m_tgt;
  logic        m_busy, m_dec, m_pcross, m_wrap;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model the cycle, queue the expectation, clock, then compare what comes out.
  task automatic step(input string tag, input logic rst, input logic la, input logic [15:0] addr,
                      input logic ll, input logic lh, input logic [7:0] db, input logic br,
                      input logic [7:0] off, input logic inc);
    logic [15:0] tgt;
    exp_t        e;
    string       t;
    reset            = rst;
    bus.load_addr_en = la;
    bus.addr_in      = addr;
    bus.load_low_en  = ll;
    bus.load_high_en = lh;
    bus.db_in        = db;
    bus.branch_en    = br;
    bus.branch_off   = off;
    bus.inc_pc       = inc;

    if (rst) begin
      m_pc = 16'hFFFC; m_busy = 1'b0; m_pcross = 1'b0; m_wrap = 1'b0;
    end else if (m_busy) begin
      m_busy = 1'b0; m_pcross = 1'b0; m_wrap = 1'b0;
      if (la) begin
        m_pc = addr;
      end else begin
        m_wrap = m_dec ? (m_tgt[15:8] == 8'hFF) : (m_tgt[15:8] == 8'h00);
        m_pc   = m_tgt;
      end
    end else begin
      m_pcross = 1'b0; m_wrap = 1'b0;
      if (la) begin
        m_pc = addr;
      end else if (ll || lh) begin
        if (lh) m_pc[15:8] = db;
        if (ll) m_pc[7:0]  = db;
      end else if (br) begin
        tgt = m_pc + {{8{off[7]}}, off};
        if (tgt[15:8] != m_pc[15:8]) begin
          m_tgt = tgt; m_dec = off[7]; m_busy = 1'b1; m_pcross = 1'b1;
          m_pc[7:0] = tgt[7:0];
        end else begin
          m_pc = tgt;
        end
      end else if (inc) begin
        m_wrap = (m_pc == 16'hFFFF);
        m_pc   = m_pc + 16'd1;
      end
    end
    exp_q.push_back('{pc: m_pc, pcross: m_pcross, busy: m_busy, wrap: m_wrap});
    tag_q.push_back(tag);

    @(posedge fclk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_eq({t, ".pc"},     bus.pc_out,             e.pc);
    check_eq({t, ".dblo"},   16'(bus.db_low_out),    16'(e.pc[7:0]));
    check_eq({t, ".dbhi"},   16'(bus.db_high_out),   16'(e.pc[15:8]));
    check_eq({t, ".pcross"}, 16'(bus.page_cross),    16'(e.pcross));
    check_eq({t, ".busy"},   16'(bus.busy),          16'(e.busy));
`ifdef PC_WRAP_FLAG_EN
    check_eq({t, ".wrap"},   16'(bus.pc_wrap),       16'(e.wrap));
`endif
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0, 8'h0, 1'b0);
  endtask

  task automatic ld(input string tag, input logic [15:0] addr);
    step(tag, 1'b0, 1'b1, addr, 1'b0, 1'b0, 8'h0, 1'b0, 8'h0, 1'b0);
  endtask

  task automatic branch(input string tag, input logic [7:0] off);
    step(tag, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b1, off, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.inc_pc = 1'b0; bus.branch_en = 1'b0; bus.branch_off = '0;
    bus.load_low_en = 1'b0; bus.load_high_en = 1'b0; bus.db_in = '0;
    bus.load_addr_en = 1'b0; bus.addr_in = '0;
    m_pc = '0; m_tgt = '0; m_busy = 1'b0; m_dec = 1'b0; m_pcross = 1'b0; m_wrap = 1'b0;

    step("rst_inc", 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0, 8'h0, 1'b1);
    check_eq("rst_pc_const", bus.pc_out, 16'hFFFC);
    step("rst_hold", 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 8'h0, 1'b1, 8'h7F, 1'b1);

    ld("ld_12ff", 16'h12FF);
    step("inc_carry", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0, 8'h0, 1'b1);
    check_eq("inc_carry_const", bus.pc_out, 16'h1300);
    ld("ld_ffff", 16'hFFFF);
    step("inc_wrap", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0, 8'h0, 1'b1);
    check_eq("inc_wrap_const", bus.pc_out, 16'h0000);

    ld("ld_2010", 16'h2010);
    branch("br_nocross", 8'h05);
    check_eq("br_nocross_const", bus.pc_out, 16'h2015);

    ld("ld_20f0", 16'h20F0);
    branch("br_fwd", 8'h20);
    check_eq("br_fwd_const", bus.pc_out, 16'h2010);
    idle("fix_fwd");
    check_eq("fix_fwd_const", bus.pc_out, 16'h2110);
    idle("after_fwd");

    ld("ld_2005", 16'h2005);
    branch("br_bwd", 8'hF0);
    check_eq("br_bwd_const", bus.pc_out, 16'h20F5);
    idle("fix_bwd");
    check_eq("fix_bwd_const", bus.pc_out, 16'h1FF5);

    step("prio_addr", 1'b0, 1'b1, 16'hC000, 1'b0, 1'b0, 8'h0, 1'b1, 8'h7F, 1'b1);
    check_eq("prio_addr_const", bus.pc_out, 16'hC000);
    step("prio_byte", 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 8'h11, 1'b1, 8'h40, 1'b1);

    ld("ld_abort", 16'h20F0);
    branch("br_abort", 8'h20);
    ld("fix_abort", 16'h8000);
    check_eq("fix_abort_const", bus.pc_out, 16'h8000);
    idle("after_abort");

    ld("ld_ign", 16'h20F0);
    branch("br_ign", 8'h20);
    step("fix_inc_ign", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0, 8'h0, 1'b1);
    step("inc_after", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0, 8'h0, 1'b1);
    branch("br_ign2", 8'hA0);
    step("fix_ld_ign", 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 8'h33, 1'b1, 8'h10, 1'b0);

    step("ld_both", 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h0, 1'b0);
    check_eq("ld_both_const", bus.pc_out, 16'hA5A5);

    ld("ld_rst", 16'h20F0);
    branch("br_rst", 8'h20);
    step("fix_rst", 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0, 8'h0, 1'b1);
    check_eq("fix_rst_busy", 16'(bus.busy), 16'h0000);
    idle("after_rst");

    ld("ld_fff0", 16'hFFF0);
    branch("br_wrap_up", 8'h20);
    idle("fix_wrap_up");
    ld("ld_0005", 16'h0005);
    branch("br_wrap_dn", 8'hF0);
    idle("fix_wrap_dn");
    check_eq("fix_wrap_dn_const", bus.pc_out, 16'hFFF5);

    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 7) == 0), 16'($urandom),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 8'($urandom),
           ($urandom_range(0, 2) == 0), 8'($urandom),
           ($urandom_range(0, 1) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
